// File: rtl/conv_job_loader.sv
// conv_job_loader: host-side job front end for the convolution accelerator.
// Accepts a streamed job (IFM pixels, then P row-major 4x4 kernels), writes
// it into the input/weight memories, then runs the controller start/done
// handshake and reports completion with a one-cycle job_done pulse.
module conv_job_loader #(
  parameter int P         = 2,
  parameter int DATA_W    = 8,
  parameter int IFM_DIM   = 16,
  parameter int ADDR_W    = 10,
  parameter int START_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_go,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              job_done,
  output logic              err
);

  localparam int IFM_WORDS = IFM_DIM * IFM_DIM;
  localparam int W_WORDS   = 16 * P;
  localparam logic [ADDR_W-1:0] IFM_LAST = ADDR_W'(IFM_WORDS - 1);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(W_WORDS - 1);
  localparam int CYC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(START_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IFM,
    LOAD_W,
    START,
    RUN,
    FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ifm_cnt;
  logic [ADDR_W-1:0] w_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic              accept;
  logic              ifm_final;
  logic              w_final;
  logic              frame_err;
  logic              job_go;

  // Handshake decode. s_ready depends only on the state register, so there
  // is no combinational path from s_valid back to s_ready.
  assign s_ready   = (state == LOAD_IFM) || (state == LOAD_W);
  assign busy      = (state != IDLE);
  assign start     = (state == START);
  assign job_done  = (state == FIN);
  assign accept    = s_valid & s_ready;
  assign job_go    = (state == IDLE) && cmd_go;
  assign ifm_final = (ifm_cnt == IFM_LAST);
  assign w_final   = (w_cnt == W_LAST);

  // A beat is mis-framed if s_last is set anywhere except the final weight
  // beat, or missing on that final beat. The beat itself is still written.
  assign frame_err = accept && (((state == LOAD_IFM) && s_last) ||
                                ((state == LOAD_W) && (s_last != w_final)));

  // State register; reset aborts any job in flight.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from the values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic for the job sequence.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (cmd_go) state_nxt = LOAD_IFM;
      LOAD_IFM: if (accept) begin
                  if (frame_err)      state_nxt = IDLE;
                  else if (ifm_final) state_nxt = LOAD_W;
                end
      LOAD_W:   if (accept) begin
                  if (frame_err)    state_nxt = IDLE;
                  else if (w_final) state_nxt = START;
                end
      START:    if (cyc_cnt == CYC_LAST) state_nxt = RUN;
      RUN:      if (done) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Address counters: cleared when a job is accepted, stepped per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_cnt <= '0;
      w_cnt   <= '0;
    end else if (job_go) begin
      ifm_cnt <= '0;
      w_cnt   <= '0;
    end else if (accept && (state == LOAD_IFM)) begin
      ifm_cnt <= ifm_cnt + 1'b1;
    end else if (accept && (state == LOAD_W)) begin
      w_cnt <= w_cnt + 1'b1;
    end
  end

  // Counts how long start has been held; idles at zero outside START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cyc_cnt <= '0;
    else if (state != START) cyc_cnt <= '0;
    else                     cyc_cnt <= cyc_cnt + 1'b1;
  end

  // Sticky framing error, cleared only by the next accepted job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (job_go)    err <= 1'b0;
    else if (frame_err) err <= 1'b1;
  end

  // Registered memory write port: one write per accepted beat, next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_sel   <= (state == LOAD_W);
        mem_addr  <= (state == LOAD_W) ? w_cnt : ifm_cnt;
        mem_wdata <= s_data;
      end
    end
  end

endmodule
